multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
REQ-003 Clock  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract; sampled with start.
REQ-007 ci  input  1  carry-in for add; sampled with start; ignored when sub=1.
REQ-008 A  input  WIDTH  first operand; sampled with start.
REQ-009 B  input  WIDTH  second operand; sampled with start.
REQ-010 busy  output  1  high while an operation is in progress (state BUSY or DONE).
REQ-011 done  output  1  one-cycle pulse; S, co and ovf are valid while done=1.
REQ-012 S  output  WIDTH  registered result.
REQ-013 co  output  1  carry out of the MSB (for subtract: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 The block SHALL implement the FSM states IDLE, BUSY and DONE, with NCHUNK = WIDTH/CHUNK.
REQ-016 IDLE with start=1 at an edge SHALL do all of the following on that edge:
- latch A into the operand register;
- latch B, or ~B when sub=1, into the operand register;
- latch the carry as ci, or 1 when sub=1;
- clear S, co and ovf;
- clear the chunk index;
- go to BUSY.
REQ-017 In IDLE with start=0, the block SHALL hold all registers.
REQ-018 Each BUSY edge SHALL add chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK) of the latched operands plus the registered carry, write those bits of S, register the chunk carry-out, and increment i.
REQ-019 On the edge processing chunk NCHUNK-1, the block SHALL update co and ovf and go to DONE.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-021 done SHALL equal (state==DONE), and busy SHALL equal (state!=IDLE); both SHALL be registered-state decodes with no combinational path from inputs.
REQ-022 Latency: done SHALL be high during the cycle that starts NCHUNK edges after the edge that sampled start. For CHUNK=WIDTH this is the cycle immediately following the start edge.
REQ-023 The block SHALL ignore start in BUSY and DONE; the operation in flight SHALL NOT be disturbed.
REQ-024 A, B, sub and ci SHALL NOT affect an operation in flight once latched.
REQ-025 S, co and ovf SHALL hold their final values after DONE until the next accepted start.
REQ-026 Intermediate S values during BUSY are not valid; they SHALL contain only completed low chunks, with upper bits 0.
REQ-027 Result SHALL equal (A + B + ci) mod 2^WIDTH for add, and (A - B) mod 2^WIDTH for subtract.
REQ-028 Back-to-back operation: start held high continuously SHALL be accepted in the IDLE cycle following each DONE, giving one result every NCHUNK+2 cycles.

Reset
REQ-029 Resetn=0 SHALL immediately, without waiting for Clock, force the following: state=IDLE, chunk index=0, carry=0, S=0, co=0, ovf=0, busy=0, done=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 After Resetn deasserts, the first accepted start SHALL behave identically to the first start after power-up.

Verification
REQ-032 With WIDTH=16, CHUNK=4, the bench SHALL cover these directed scenarios:
- A=0x1234, B=0x0FED, sub=0, ci=0 -> S=0x2221, co=0, ovf=0; done exactly 4 edges after the start edge, high for 1 cycle.
- A=0xFFFF, B=0x0001, ci=0 -> S=0x0000, co=1, ovf=0; A=0x7FFF, B=0x0000, ci=1 -> S=0x8000, co=0, ovf=1.
- sub=1, A=0x0005, B=0x0007, ci=1 (ignored) -> S=0xFFFE, co=0, ovf=0; sub=1, A=0x8000, B=0x0001 -> S=0x7FFF, co=1, ovf=1.
- start pulsed again, with different operands, 2 cycles into BUSY -> ignored; first result unchanged; exactly one done pulse.
- Resetn dropped between Clock edges during BUSY -> S=0, busy=0 immediately; no done; a following start returns a correct result.
REQ-033 The bench SHALL repeat the 0x1234+0x0FED case with CHUNK=16 (done 1 edge after start) and CHUNK=1 (done 16 edges after start), and SHALL run a random add/sub comparison against a reference sum.

Source files
------------

// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock over WIDTH/CHUNK cycles.
// The result, carry-out and two's-complement overflow are valid during the one-cycle done pulse.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             cy_q, cy_d, co_q, co_d, ovf_q, ovf_d;

  logic [CHUNK:0]   csum;
  logic [31:0]      base;
  logic             cin_msb;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    base    = 32'(idx_q) * 32'(CHUNK);
    csum    = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]} + (CHUNK+1)'(cy_q);
    // On the final chunk csum[CHUNK-1] is the result MSB, so this recovers the carry into it.
    cin_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ csum[CHUNK-1];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          cy_d    = sub ? 1'b1 : ci;
          s_d     = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_d[base +: CHUNK] = csum[CHUNK-1:0];
        cy_d  = csum[CHUNK];
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          co_d    = csum[CHUNK];
          ovf_d   = cin_msb ^ csum[CHUNK];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three instances (CHUNK 4, 16, 1) share stimulus and are
// checked against an integer-arithmetic reference for result, flags and done latency.
module tb_multicycle_adder;

  logic Clock = 1'b0;
  logic Resetn, start, sub, ci;
  logic [15:0] A, B;

  logic [2:0][15:0] s_w;
  logic [2:0]       busy_w, done_w, co_w, ovf_w;

  localparam int NCH [3] = '{4, 1, 16};

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .Clock(Clock), .Resetn(Resetn), .start(start), .sub(sub), .ci(ci), .A(A), .B(B),
    .busy(busy_w[0]), .done(done_w[0]), .S(s_w[0]), .co(co_w[0]), .ovf(ovf_w[0]));
  multicycle_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .Clock(Clock), .Resetn(Resetn), .start(start), .sub(sub), .ci(ci), .A(A), .B(B),
    .busy(busy_w[1]), .done(done_w[1]), .S(s_w[1]), .co(co_w[1]), .ovf(ovf_w[1]));
  multicycle_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .Clock(Clock), .Resetn(Resetn), .start(start), .sub(sub), .ci(ci), .A(A), .B(B),
    .busy(busy_w[2]), .done(done_w[2]), .S(s_w[2]), .co(co_w[2]), .ovf(ovf_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  task automatic model(input logic [15:0] a, b, input logic sb, c,
                       output logic [15:0] rs, output logic rco, rov);
    int ua, ub, sa, sbv, ur, sr;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    if (sb) begin
      ur = ua - ub; sr = sa - sbv; rco = (ua >= ub);
    end else begin
      ur = ua + ub + int'(c); sr = sa + sbv + int'(c); rco = (ur > 65535);
    end
    rs  = ur[15:0];
    rov = (sr > 32767) || (sr < -32768);
  endtask

  task automatic wait_idle();
    @(negedge Clock);
    for (int i = 0; i < 40 && busy_w != 3'b000; i++) @(negedge Clock);
    chk("idle_before_start", 32'(busy_w), 32'd0);
  endtask

  task automatic op(input string tag, input logic [15:0] a, b, input logic sb, c,
                    input logic [2:0] mask, input bit poke);
    logic [15:0] es; logic eco, eov;
    int lat [3]; int cnt [3];
    logic [15:0] rs [3]; logic rco [3]; logic rov [3];
    model(a, b, sb, c, es, eco, eov);
    wait_idle();
    A = a; B = b; sub = sb; ci = c; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy_w & mask), 32'(mask));
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; cnt[k] = 0; rs[k] = 'x; rco[k] = 1'bx; rov[k] = 1'bx;
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clock);
      if (poke && n == 2) begin start = 1'b1; A = ~a; B = a ^ 16'h5A5A; sub = ~sb; ci = ~c; end
      if (poke && n == 3) start = 1'b0;
      if (n == 1 && mask[0]) chk({tag, "_partial_hi"}, 32'(s_w[0][15:4]), 32'd0);
      for (int k = 0; k < 3; k++) begin
        if (mask[k] && done_w[k]) begin
          cnt[k]++;
          if (lat[k] == 0) begin
            lat[k] = n; rs[k] = s_w[k]; rco[k] = co_w[k]; rov[k] = ovf_w[k];
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        string t;
        t = $sformatf("%s_c%0d", tag, 16 / NCH[k]);
        chk({t, "_lat"},  32'(lat[k]), 32'(NCH[k]));
        chk({t, "_npulse"}, 32'(cnt[k]), 32'd1);
        chk({t, "_S"},    32'(rs[k]),  32'(es));
        chk({t, "_co"},   32'(rco[k]), 32'(eco));
        chk({t, "_ovf"},  32'(rov[k]), 32'(eov));
        chk({t, "_hold"}, 32'(s_w[k]), 32'(es));
      end
    end
  endtask

  initial begin
    Resetn = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0; A = '0; B = '0;
    #12;
    chk("rst_busy", 32'(busy_w), 32'd0);
    chk("rst_done", 32'(done_w), 32'd0);
    chk("rst_S",    32'(s_w[0]), 32'd0);
    chk("rst_flags", 32'({co_w, ovf_w}), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    op("add1234", 16'h1234, 16'h0FED, 1'b0, 1'b0, 3'b111, 1'b0);
    op("addwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b111, 1'b0);
    op("addovf",  16'h7FFF, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b0);
    op("sub5m7",  16'h0005, 16'h0007, 1'b1, 1'b1, 3'b111, 1'b0);
    op("subovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 3'b111, 1'b0);
    // CHUNK=16 finishes before the poke lands and would legitimately accept it.
    op("poke",    16'h1234, 16'h0FED, 1'b0, 1'b0, 3'b101, 1'b1);

    // Asynchronous reset in the middle of BUSY.
    wait_idle();
    A = 16'hABCD; B = 16'h1111; sub = 1'b0; ci = 1'b1; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("arst_S",    32'(s_w[0]), 32'd0);
    chk("arst_busy", 32'(busy_w), 32'd0);
    chk("arst_done", 32'(done_w), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    begin
      int dn;
      dn = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge Clock);
        if (done_w != 3'b000) dn++;
      end
      chk("arst_nodone", 32'(dn), 32'd0);
    end
    op("after_rst", 16'h1234, 16'h0FED, 1'b0, 1'b0, 3'b111, 1'b0);

    for (int r = 0; r < 20; r++) begin
      logic [15:0] ra, rb; logic rsub, rci;
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rci = 1'($urandom);
      op($sformatf("rnd%0d", r), ra, rb, rsub, rci, 3'b111, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
